ece385_sprite_fetcher: RTL and testbench
========================================

ECE385_SPRITE_FETCHER -- requirements
Module: ece385_sprite_fetcher

Interface
REQ-001 SHALL have parameter SPRITE_DIM, default 64, meaning sprite width and height in pixels (power of two).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning sprite-RAM word address width (log2 of SPRITE_DIM squared).
REQ-003 SHALL have parameter TRANSPARENT_KEY, default 16'hF81F, meaning 16-bit colour treated as transparent.
REQ-004 SHALL have port clk  in  1  sole clock, shared with the sprite-RAM read port.
REQ-005 SHALL have port reset  in  1  reset; one clock, reset synchronous and active-high.
REQ-006 SHALL have port line_start  in  1  single-cycle pulse at start of horizontal blanking.
REQ-007 SHALL have port line_y  in  10  screen row about to be displayed, sampled with line_start.
REQ-008 SHALL have port sprite_x, sprite_y  in  10 each  sprite top-left screen position, sampled with line_start.
REQ-009 SHALL have port sprite_en  in  1  sprite visible, sampled with line_start.
REQ-010 SHALL have port draw_x  in  10  current pixel column during active video.
REQ-011 SHALL have port active  in  1  active-video qualifier for draw_x.
REQ-012 SHALL have port mem_address  out  ADDR_W  read address to sprite-RAM 16-bit port.
REQ-013 SHALL have port mem_chipselect, mem_clken  out  1  asserted only while fetching.
REQ-014 SHALL have port mem_write  out  1  constant 0.
REQ-015 SHALL have port mem_readdata  in  16  RAM data, valid one cycle after mem_address.
REQ-016 SHALL have port pix_color  out  16  sprite pixel colour; pix_opaque  out  1  pixel overrides background.
REQ-017 SHALL have port fetch_busy  out  1  fetch in progress; fetch_overrun  out  1  sticky error.

Function
REQ-018 SHALL implement FSM IDLE, FETCH, DRAIN.
REQ-019 On line_start SHALL latch sprite_x/sprite_y/sprite_en, compute row = (line_y - sprite_y) mod 1024, clear buf_valid.
REQ-020 If sprite_en and row < SPRITE_DIM SHALL enter FETCH with col = 0; else remain/return IDLE.
REQ-021 In FETCH SHALL drive mem_address = row*SPRITE_DIM + col, increment col each cycle, write mem_readdata into line buffer entry col-1 (from second FETCH cycle).
REQ-022 After issuing col = SPRITE_DIM-1 SHALL enter DRAIN for one cycle, store final word, set buf_valid, go IDLE; fetch = SPRITE_DIM+1 cycles.
REQ-023 line_start during FETCH/DRAIN SHALL abort, set fetch_overrun, restart per REQ-019/020 same cycle.
REQ-024 Line buffer SHALL be SPRITE_DIM x 16 bits, single-buffered, read only when buf_valid.
REQ-025 Output SHALL be registered, 1-cycle latency from draw_x: dx = (draw_x - sprite_x_latched) mod 1024; pix_opaque = active & buf_valid & dx < SPRITE_DIM & buf[dx] != TRANSPARENT_KEY.
REQ-026 pix_color SHALL equal buf[dx] when pix_opaque, else 16'h0000.
REQ-027 Vertical/horizontal wrap SHALL follow mod-1024 arithmetic (sprite_x = 1000 covers columns 1000..1023 and 0..39).
REQ-028 fetch_busy SHALL be high in FETCH and DRAIN.

Reset
REQ-029 Reset SHALL force IDLE, col = 0, buf_valid = 0, fetch_overrun = 0, pix_opaque = 0, pix_color = 0, mem_chipselect = mem_clken = 0, mem_address = 0; line buffer contents not reset.
REQ-030 Reset mid-FETCH SHALL abandon the line; no pixel shown until next complete fetch.

Configuration
REQ-031 With SPRITE_FETCHER_HFLIP_EN defined SHALL add input hflip (1 bit, sampled with line_start); when latched high the buffer index is SPRITE_DIM-1-dx.
REQ-032 Without SPRITE_FETCHER_HFLIP_EN there SHALL be no hflip port and the index is dx.

Structure
REQ-033 Package ece385_sprite_pkg SHALL hold SPRITE_DIM, TRANSPARENT_KEY defaults, FSM state enum, and the screen-coordinate width (10).
REQ-034 Line buffer SHALL be sub-module ece385_sprite_linebuf (one write port, one registered read port).

Verification
REQ-035 RAM preloaded addr = value; sprite (100,50), line_y = 53, line_start -> addresses 192..255 over 64 cycles, busy 65 cycles, draw_x = 100 gives pix_color 16'd192 next cycle.
REQ-036 Word at row 0 col 5 = 16'hF81F; line_y = 50, draw_x = 105 -> pix_opaque 0, pix_color 0.
REQ-037 line_y = 49 or 114, or sprite_en = 0 -> no mem_chipselect, pix_opaque 0 across whole line.
REQ-038 Second line_start 30 cycles into fetch -> fetch_overrun 1, new fetch from col 0, overrun held until reset.
REQ-039 sprite_x = 1000, draw_x = 10 -> pixel from buffer column 34 displayed.
REQ-040 With SPRITE_FETCHER_HFLIP_EN, hflip = 1, draw_x = sprite_x -> buffer column 63 displayed.

Source files
------------

// File: rtl/ece385_sprite_pkg.sv
// Shared constants, coordinate width and fetch FSM encoding for the sprite fetcher.
package ece385_sprite_pkg;

    localparam int          SPRITE_DIM_DEFAULT      = 64;
    localparam logic [15:0] TRANSPARENT_KEY_DEFAULT = 16'hF81F;
    localparam int          COORD_W                 = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ece385_sprite_linebuf.sv
// One-line sprite pixel buffer: one write port and one registered read port.
// Contents are deliberately not reset; readers qualify with their own valid flag.
module ece385_sprite_linebuf #(
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data_q <= mem[rd_idx];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ece385_sprite_fetcher.sv
// Per-scanline sprite row fetcher: copies one sprite row into a line buffer during
// blanking, then serves keyed pixels against draw_x. Define SPRITE_FETCHER_HFLIP_EN for mirroring.
module ece385_sprite_fetcher
    import ece385_sprite_pkg::*;
#(
    parameter int          SPRITE_DIM      = SPRITE_DIM_DEFAULT,
    parameter int          ADDR_W          = 12,
    parameter logic [15:0] TRANSPARENT_KEY = TRANSPARENT_KEY_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_start,
    input  logic [COORD_W-1:0] line_y,
    input  logic [COORD_W-1:0] sprite_x,
    input  logic [COORD_W-1:0] sprite_y,
    input  logic               sprite_en,
`ifdef SPRITE_FETCHER_HFLIP_EN
    input  logic               hflip,
`endif
    input  logic [COORD_W-1:0] draw_x,
    input  logic               active,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_chipselect,
    output logic               mem_clken,
    output logic               mem_write,
    input  logic [15:0]        mem_readdata,
    output logic [15:0]        pix_color,
    output logic               pix_opaque,
    output logic               fetch_busy,
    output logic               fetch_overrun
);

    localparam int COL_W = $clog2(SPRITE_DIM);
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(SPRITE_DIM - 1);
    localparam logic [COORD_W-1:0] DIM_C    = COORD_W'(SPRITE_DIM);

    fetch_state_t       state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [COL_W-1:0]   row_q, row_d;
    logic [COORD_W-1:0] sx_q, sx_d;
    logic               buf_valid_q, buf_valid_d;
    logic               overrun_q, overrun_d;
    logic               qual_q, qual_d;
    logic               hflip_q, hflip_d;

    logic [COORD_W-1:0] row_full;
    logic [COORD_W-1:0] dx;
    logic               wr_en;
    logic [COL_W-1:0]   wr_idx;
    logic [COL_W-1:0]   rd_idx;
    logic [15:0]        rd_data;
    logic               fetching;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sx_d        = sx_q;
        buf_valid_d = buf_valid_q;
        overrun_d   = overrun_q;
        hflip_d     = hflip_q;
        wr_en       = 1'b0;
        wr_idx      = col_q - COL_W'(1);
        row_full    = line_y - sprite_y;

        // Read data trails the address by one cycle, so each write lands one column behind.
        case (state_q)
            ST_FETCH: begin
                wr_en = (col_q != '0);
                if (col_q == COL_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            ST_DRAIN: begin
                wr_en       = 1'b1;
                wr_idx      = col_q;
                buf_valid_d = 1'b1;
                col_d       = '0;
                state_d     = ST_IDLE;
            end
            default: ;
        endcase

        // A new line always wins; catching one mid-fetch marks the overrun.
        if (line_start) begin
            if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end
            sx_d        = sprite_x;
`ifdef SPRITE_FETCHER_HFLIP_EN
            hflip_d     = hflip;
`else
            hflip_d     = 1'b0;
`endif
            buf_valid_d = 1'b0;
            col_d       = '0;
            row_d       = row_full[COL_W-1:0];
            state_d     = (sprite_en && (row_full < DIM_C)) ? ST_FETCH : ST_IDLE;
        end
    end

    always_comb begin
        dx     = draw_x - sx_q;
        qual_d = active & buf_valid_q & (dx < DIM_C);
        rd_idx = hflip_q ? (COL_LAST - dx[COL_W-1:0]) : dx[COL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            sx_q        <= '0;
            buf_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            qual_q      <= 1'b0;
            hflip_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sx_q        <= sx_d;
            buf_valid_q <= buf_valid_d;
            overrun_q   <= overrun_d;
            qual_q      <= qual_d;
            hflip_q     <= hflip_d;
        end
    end

    ece385_sprite_linebuf #(
        .DEPTH  (SPRITE_DIM),
        .IDX_W  (COL_W),
        .DATA_W (16)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (mem_readdata),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign fetching       = (state_q == ST_FETCH);
    assign mem_chipselect = fetching;
    assign mem_clken      = fetching;
    assign mem_write      = 1'b0;
    assign mem_address    = fetching ? ADDR_W'({row_q, col_q}) : '0;
    assign fetch_busy     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign fetch_overrun  = overrun_q;
    assign pix_opaque     = qual_q && (rd_data != TRANSPARENT_KEY);
    assign pix_color      = pix_opaque ? rd_data : 16'h0000;

endmodule

// File: tb/tb_ece385_sprite_fetcher.sv
// Self-checking bench for ece385_sprite_fetcher with a sprite-RAM model and pixel scoreboard.
module tb_ece385_sprite_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = '0;
    logic [9:0]  sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic        sprite_en = 1'b0;
    logic        hflip = 1'b0;
    logic [9:0]  draw_x = '0;
    logic        active = 1'b0;
    logic [11:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [15:0] mem_readdata = '0;
    logic [15:0] pix_color;
    logic        pix_opaque;
    logic        fetch_busy;
    logic        fetch_overrun;

    ece385_sprite_fetcher dut (
        .clk            (clk),
        .reset          (reset),
        .line_start     (line_start),
        .line_y         (line_y),
        .sprite_x       (sprite_x),
        .sprite_y       (sprite_y),
        .sprite_en      (sprite_en),
`ifdef SPRITE_FETCHER_HFLIP_EN
        .hflip          (hflip),
`endif
        .draw_x         (draw_x),
        .active         (active),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata),
        .pix_color      (pix_color),
        .pix_opaque     (pix_opaque),
        .fetch_busy     (fetch_busy),
        .fetch_overrun  (fetch_overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [4096];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken && !mem_write) begin
            mem_readdata <= ram[mem_address];
        end
    end

    typedef struct packed {
        logic        opaque;
        logic [15:0] color;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model_buf [64];
    logic        model_valid = 1'b0;
    logic [9:0]  model_sx = '0;
    logic        model_hflip = 1'b0;
    logic        exp_overrun = 1'b0;
    logic [9:0]  cur_row = '0;
    logic        cur_vis = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input logic [9:0] y, input logic [9:0] sx, input logic [9:0] sy,
                              input logic en, input logic hf);
        line_y    = y;
        sprite_x  = sx;
        sprite_y  = sy;
        sprite_en = en;
        hflip     = hf;
        cur_row   = y - sy;
        cur_vis   = en && (cur_row < 10'd64);
        if (fetch_busy) exp_overrun = 1'b1;
        line_start = 1'b1;
        tick();
        line_start  = 1'b0;
        model_valid = 1'b0;
        model_sx    = sx;
`ifdef SPRITE_FETCHER_HFLIP_EN
        model_hflip = hf;
`else
        model_hflip = 1'b0;
`endif
    endtask

    task automatic finish_line(input string tag);
        int n;
        int cs_n;
        n = 0;
        cs_n = 0;
        while (fetch_busy && n < 200) begin
            if (mem_chipselect) begin
                chk({tag, "_addr"}, 32'(mem_address), 32'(cur_row) * 64 + 32'(cs_n));
                cs_n++;
            end
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), cur_vis ? 32'd65 : 32'd0);
        chk({tag, "_cs_cycles"}, 32'(cs_n), cur_vis ? 32'd64 : 32'd0);
        chk({tag, "_cs_idle"}, 32'(mem_chipselect), 32'd0);
        chk({tag, "_overrun"}, 32'(fetch_overrun), 32'(exp_overrun));
        if (cur_vis) begin
            for (int c = 0; c < 64; c++) model_buf[c] = ram[32'(cur_row) * 64 + c];
            model_valid = 1'b1;
        end
        $display("line %s: row=%0d visible=%0d busy_cycles=%0d", tag, cur_row, cur_vis, n);
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic act);
        exp_t        e;
        exp_t        got;
        logic [9:0]  dx;
        int          idx;
        logic [15:0] v;
        draw_x = x;
        active = act;
        dx = x - model_sx;
        e = '0;
        if (act && model_valid && dx < 10'd64) begin
            idx = model_hflip ? 63 - int'(dx) : int'(dx);
            v = model_buf[idx];
            if (v != 16'hF81F) begin
                e.opaque = 1'b1;
                e.color  = v;
            end
        end
        sb_q.push_back(e);
        tick();
        active = 1'b0;
        got = sb_q.pop_front();
        chk({tag, "_opaque"}, 32'(pix_opaque), 32'(got.opaque));
        chk({tag, "_color"}, 32'(pix_color), 32'(got.color));
        $display("pixel %s: draw_x=%0d opaque=%0d color=0x%04h", tag, x, pix_opaque, pix_color);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 16'(i);
        ram[5] = 16'hF81F;

        repeat (3) tick();
        chk("rst_opaque", 32'(pix_opaque), 32'd0);
        chk("rst_color", 32'(pix_color), 32'd0);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_overrun", 32'(fetch_overrun), 32'd0);
        chk("mem_write", 32'(mem_write), 32'd0);
        reset = 1'b0;
        tick();

        start_line(10'd53, 10'd100, 10'd50, 1'b1, 1'b0);
        finish_line("y53");
        pix("y53_x100", 10'd100, 1'b1);
        pix("y53_x163", 10'd163, 1'b1);
        pix("y53_x164", 10'd164, 1'b1);
        pix("y53_x99", 10'd99, 1'b1);
        pix("y53_inactive", 10'd100, 1'b0);
        pix("y53_x130", 10'd130, 1'b1);

        start_line(10'd50, 10'd100, 10'd50, 1'b1, 1'b0);
        finish_line("y50");
        pix("y50_key", 10'd105, 1'b1);
        pix("y50_x104", 10'd104, 1'b1);

        start_line(10'd49, 10'd100, 10'd50, 1'b1, 1'b0);
        finish_line("y49");
        pix("y49_x100", 10'd100, 1'b1);
        start_line(10'd114, 10'd100, 10'd50, 1'b1, 1'b0);
        finish_line("y114");
        pix("y114_x120", 10'd120, 1'b1);
        start_line(10'd53, 10'd100, 10'd50, 1'b0, 1'b0);
        finish_line("dis");
        pix("dis_x100", 10'd100, 1'b1);

        start_line(10'd53, 10'd1000, 10'd50, 1'b1, 1'b0);
        finish_line("xwrap");
        pix("xwrap_x10", 10'd10, 1'b1);
        pix("xwrap_x1023", 10'd1023, 1'b1);
        pix("xwrap_x1000", 10'd1000, 1'b1);
        pix("xwrap_x40", 10'd40, 1'b1);

        start_line(10'd10, 10'd100, 10'd1000, 1'b1, 1'b0);
        finish_line("ywrap");
        pix("ywrap_x100", 10'd100, 1'b1);

`ifdef SPRITE_FETCHER_HFLIP_EN
        start_line(10'd53, 10'd100, 10'd50, 1'b1, 1'b1);
        finish_line("hflip");
        pix("hflip_x100", 10'd100, 1'b1);
        pix("hflip_x163", 10'd163, 1'b1);
`endif

        start_line(10'd53, 10'd100, 10'd50, 1'b1, 1'b0);
        repeat (30) tick();
        chk("pre_overrun", 32'(fetch_overrun), 32'd0);
        start_line(10'd60, 10'd100, 10'd50, 1'b1, 1'b0);
        chk("overrun_set", 32'(fetch_overrun), 32'd1);
        finish_line("restart");
        pix("restart_x100", 10'd100, 1'b1);
        start_line(10'd53, 10'd100, 10'd50, 1'b1, 1'b0);
        finish_line("sticky");

        start_line(10'd53, 10'd100, 10'd50, 1'b1, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_overrun = 1'b0;
        model_valid = 1'b0;
        chk("midrst_busy", 32'(fetch_busy), 32'd0);
        chk("midrst_cs", 32'(mem_chipselect), 32'd0);
        chk("midrst_overrun", 32'(fetch_overrun), 32'd0);
        pix("midrst_x100", 10'd100, 1'b1);
        pix("midrst_x120", 10'd120, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
